// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
//
// Conditions four bouncy, asynchronous switch contacts (left lever, right
// lever, hazard button, brake pedal) into clean registered requests for the
// tail-light controller.
//
// Per channel: 2-flop synchronizer -> debouncer (debounced level plus a
// stability counter) -> output logic. A new level is accepted only after the
// synchronized input has differed from the debounced level for
// DEBOUNCE_CYCLES consecutive cycles. Latency from a clean raw step to the
// output is 2 + DEBOUNCE_CYCLES cycles.
//
// Optional feature macro: HAZARD_TOGGLE_EN
//   defined   : each debounced press of the hazard button toggles io_H
//   undefined : io_H follows the debounced hazard button level
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a new level (2..2^24-1)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   io_swL    in   raw left-turn lever contact
//   io_swR    in   raw right-turn lever contact
//   io_swH    in   raw hazard pushbutton
//   io_swB    in   raw brake pedal contact
//   io_L      out  left-turn request (suppressed during a lever fault)
//   io_R      out  right-turn request (suppressed during a lever fault)
//   io_H      out  hazard request
//   io_B      out  brake request
//   io_fault  out  left and right levers both debounced high
// -----------------------------------------------------------------------------
module switch_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic io_swL,
    input  logic io_swR,
    input  logic io_swH,
    input  logic io_swB,
    output logic io_L,
    output logic io_R,
    output logic io_H,
    output logic io_B,
    output logic io_fault
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Count value on which the pending level is committed on the next edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel positions inside the per-channel vectors.
    localparam int unsigned CH_L = 0;
    localparam int unsigned CH_R = 1;
    localparam int unsigned CH_H = 2;
    localparam int unsigned CH_B = 3;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] db_q;
    logic [NCH-1:0] db_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    logic l_q, r_q, h_q, b_q, f_q;
    logic l_d, r_d, h_d, b_d, f_d;

    assign raw = {io_swB, io_swH, io_swR, io_swL};

    // -------------------------------------------------------------------------
    // Debounce next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        db_d = db_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                // Committing clears the counter, so it can never wrap.
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output next-state, computed from the next debounced levels so the output
    // register adds no latency on top of the debouncer.
    // -------------------------------------------------------------------------
    assign l_d = db_d[CH_L] & ~db_d[CH_R];
    assign r_d = db_d[CH_R] & ~db_d[CH_L];
    assign f_d = db_d[CH_L] &  db_d[CH_R];
    assign b_d = db_d[CH_B];

`ifdef HAZARD_TOGGLE_EN
    // h_q is itself the hazard latch: flip on each debounced 0->1 of the button.
    assign h_d = h_q ^ (db_d[CH_H] & ~db_q[CH_H]);
`else
    assign h_d = db_d[CH_H];
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            // NOTE: the counter array is a handful of flops rather than a RAM,
            // so it is cleared with the rest of the state; this discards any
            // partial count when reset hits mid-debounce.
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            l_q <= 1'b0;
            r_q <= 1'b0;
            h_q <= 1'b0;
            b_q <= 1'b0;
            f_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before the edge; blocking here would collapse the
            // two-stage synchronizer into one stage.
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            l_q <= l_d;
            r_q <= r_d;
            h_q <= h_d;
            b_q <= b_d;
            f_q <= f_d;
        end
    end

    assign io_L     = l_q;
    assign io_R     = r_q;
    assign io_H     = h_q;
    assign io_B     = b_q;
    assign io_fault = f_q;

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clock cycles required to accept a new switch level (legal range 2..2^24-1).
REQ-002 Port: clock  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; asserted when 0, sampled on rising clock edge.
REQ-004 Port: io_swL  input  1  raw left-turn lever contact, asynchronous, bouncy.
REQ-005 Port: io_swR  input  1  raw right-turn lever contact, asynchronous, bouncy.
REQ-006 Port: io_swH  input  1  raw hazard pushbutton, asynchronous, bouncy.
REQ-007 Port: io_swB  input  1  raw brake pedal contact, asynchronous, bouncy.
REQ-008 Port: io_L  output  1  conditioned left-turn request to the tail-light controller.
REQ-009 Port: io_R  output  1  conditioned right-turn request.
REQ-010 Port: io_H  output  1  conditioned hazard request.
REQ-011 Port: io_B  output  1  conditioned brake request.
REQ-012 Port: io_fault  output  1  high while left and right debounced levels are both high (lever fault).

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each channel SHALL hold a debounced level and a counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-015 Counter SHALL clear in any cycle where synchronized input equals debounced level, else increment.
REQ-016 When counter reaches DEBOUNCE_CYCLES-1 while input still differs, debounced level SHALL take the input value next cycle and counter SHALL clear.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave debounced level unchanged; counter restarts from 0 on every reversal.
REQ-018 Latency raw edge to debounced change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step.
REQ-019 Counter SHALL never wrap; it saturates implicitly by the clear in REQ-016.
REQ-020 io_L SHALL equal debounced L AND NOT debounced R; io_R SHALL equal debounced R AND NOT debounced L.
REQ-021 io_fault SHALL equal debounced L AND debounced R; io_L and io_R both 0 while io_fault is 1.
REQ-022 io_B SHALL equal debounced B, unaffected by other channels.
REQ-023 Hazard channel behaviour SHALL be per REQ-027/REQ-028.
REQ-024 All outputs SHALL be registered (no combinational path from any raw input).

Reset
REQ-025 While reset is 0 at a rising edge: synchronizers, debounced levels, counters and hazard latch SHALL clear to 0; all outputs 0 the following cycle.
REQ-026 Reset asserted mid-debounce SHALL discard partial counts; after release a held input requires full 2 + DEBOUNCE_CYCLES cycles again.

Configuration
REQ-027 With HAZARD_TOGGLE_EN defined: a 0->1 transition of debounced H SHALL toggle a hazard latch; io_H equals the latch; release has no effect.
REQ-028 Without HAZARD_TOGGLE_EN: io_H SHALL equal debounced H level (held-button semantics), no latch present.

Verification
REQ-029 DEBOUNCE_CYCLES=4, reset released, io_swB 0->1 held -> io_B rises exactly 6 cycles after input edge, stays 1.
REQ-030 DEBOUNCE_CYCLES=4, io_swL pulses 1 for 3 cycles then 0, repeated 5 times -> io_L stays 0 throughout, counter never reaches 3.
REQ-031 DEBOUNCE_CYCLES=4, io_swL and io_swR both held 1 -> after 6 cycles io_fault=1, io_L=0, io_R=0; drop io_swR -> 6 cycles later io_L=1, io_fault=0.
REQ-032 HAZARD_TOGGLE_EN defined, DEBOUNCE_CYCLES=4: press io_swH 10 cycles, release, press again 10 cycles -> io_H goes 1 after first press, 0 after second; undefined build -> io_H follows each press, 0 between.
REQ-033 DEBOUNCE_CYCLES=4, io_swB held 1, reset driven 0 at cycle 4 for 1 cycle -> io_B remains 0 and rises 6 cycles after reset returns to 1.
REQ-034 Reset held 0 with all raw inputs 1 -> all outputs 0 every cycle during reset.
